// File: rtl/mux_op_driver_if.sv
// Command, result-unit and response bundle for mux_op_driver.
// The slave view belongs to the driver; the master view feeds it.
interface mux_op_driver_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_in_data;
  logic             op_sel;
  logic             op_add;
  logic             op_sub;
  logic [WIDTH:0]   op_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH:0]   rsp_data;
  logic [1:0]       rsp_op;
  logic             rsp_err;
  logic [7:0]       err_count;
  logic             busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    input  op_result, rsp_ready,
    output cmd_ready, op_a, op_b,
    output op_in_data, op_sel, op_add, op_sub,
    output rsp_valid, rsp_data, rsp_op, rsp_err,
    output err_count, busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    output op_result, rsp_ready,
    input  cmd_ready, op_a, op_b,
    input  op_in_data, op_sel, op_add, op_sub,
    input  rsp_valid, rsp_data, rsp_op, rsp_err,
    input  err_count, busy
  );
endinterface

// File: rtl/mux_op_driver.sv
// Sequencer that issues one op to the select/add/sub result unit,
// waits its latency, and returns the checked result.
module mux_op_driver #(
  parameter int WIDTH = 8,
  parameter int LAT   = 1
) (
  input logic            CLK,
  input logic            RST,
  mux_op_driver_if.slave bus
);

  localparam int CW = (LAT < 2) ? 1 : $clog2(LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t         state;
  logic [1:0]     op_q;
  logic [WIDTH:0] exp_q;
  logic [WIDTH:0] exp_d;
  logic [CW-1:0]  cnt;
  logic           mism;

  assign bus.cmd_ready = (state == IDLE) && RST;
  assign bus.busy      = (state != IDLE);
  assign mism          = (bus.op_result != exp_q);

  always_comb begin
    exp_d = '0;
    unique case (op_q)
      2'd0: exp_d = {1'b0, bus.op_a};
      2'd1: exp_d = {1'b0, bus.op_b};
      2'd2: exp_d = {1'b0, bus.op_a} + {1'b0, bus.op_b};
      2'd3: exp_d = {1'b0, bus.op_a} - {1'b0, bus.op_b};
      default: exp_d = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state          <= IDLE;
      op_q           <= '0;
      exp_q          <= '0;
      cnt            <= '0;
      bus.op_a       <= '0;
      bus.op_b       <= '0;
      bus.op_in_data <= 1'b0;
      bus.op_sel     <= 1'b0;
      bus.op_add     <= 1'b0;
      bus.op_sub     <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_data   <= '0;
      bus.rsp_op     <= '0;
      bus.rsp_err    <= 1'b0;
      bus.err_count  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q     <= bus.cmd_op;
            bus.op_a <= bus.cmd_a;
            bus.op_b <= bus.cmd_b;
            {bus.op_sub, bus.op_add, bus.op_sel, bus.op_in_data}
              <= 4'b0001 << bus.cmd_op;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          exp_q <= exp_d;
          cnt   <= CW'(LAT);
          {bus.op_sub, bus.op_add, bus.op_sel, bus.op_in_data}
            <= 4'b0000;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == CW'(1)) begin
            bus.rsp_data  <= bus.op_result;
            bus.rsp_op    <= op_q;
            bus.rsp_err   <= mism;
            bus.rsp_valid <= 1'b1;
            if (mism && (bus.err_count != 8'hFF))
              bus.err_count <= bus.err_count + 8'd1;
            state <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_op_driver.sv
// Randomised scoreboard bench for mux_op_driver with a LAT=1
// result-unit model that can corrupt ADD results on demand.
module tb_mux_op_driver;

  localparam int W    = 8;
  localparam int MASK = (1 << (W + 1)) - 1;

  typedef struct {
    logic [W:0] data;
    logic [1:0] op;
    logic       err;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  mux_op_driver_if #(.WIDTH(W)) bus ();

  mux_op_driver #(.WIDTH(W), .LAT(1)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   hs_cyc = 0;
  int   model_errs = 0;
  bit   fault = 1'b0;
  bit   bp_mode = 1'b0;
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic int ref_result(input int op, input int a,
                                    input int b);
    case (op)
      0: return a;
      1: return b;
      2: return a + b;
      default: return (a - b + (MASK + 1)) & MASK;
    endcase
  endfunction

  function automatic logic [3:0] ctrl();
    return {bus.op_sub, bus.op_add, bus.op_sel, bus.op_in_data};
  endfunction

  always @(posedge CLK) cyc++;

  // Result unit: registers its answer on the edge ending the issue cycle.
  always @(posedge CLK or negedge RST) begin
    if (!RST) bus.op_result <= '0;
    else begin
      case (ctrl())
        4'b0001: bus.op_result <= {1'b0, bus.op_a};
        4'b0010: bus.op_result <= {1'b0, bus.op_b};
        4'b0100: bus.op_result <= {1'b0, bus.op_a} + {1'b0, bus.op_b}
                                  + (W + 1)'(fault);
        4'b1000: bus.op_result <= {1'b0, bus.op_a} - {1'b0, bus.op_b};
        default: ;
      endcase
    end
  end

  always @(negedge CLK) begin
    if (bp_mode) bus.rsp_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: pops one expectation per response handshake.
  always @(negedge CLK) begin
    exp_t e;
    #1;
    if (RST) begin
      chk("onehot", 32'(($countones(ctrl()) <= 1)), 32'd1);
      if (bus.rsp_valid && bus.rsp_ready) begin
        hs_cyc = cyc + 1;
        if (q.size() == 0) begin
          chk("unexpected_rsp", 32'(bus.rsp_data), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          if (e.err && model_errs < 255) model_errs++;
          chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
          chk("rsp_op", 32'(bus.rsp_op), 32'(e.op));
          chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          chk("err_count", 32'(bus.err_count), 32'(model_errs));
        end
      end
    end
  end

  task automatic push_exp(input int op, input int a, input int b);
    exp_t e;
    bit   f;
    f      = fault && (op == 2);
    e.data = (W + 1)'((ref_result(op, a, b) + int'(f)) & MASK);
    e.op   = 2'(op);
    e.err  = f;
    q.push_back(e);
  endtask

  // Entered and left on a falling edge.
  task automatic send(input int op, input int a, input int b,
                      output int acc);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'(op);
    bus.cmd_a     = W'(a);
    bus.cmd_b     = W'(b);
    while (!bus.cmd_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.cmd_ready) begin
      chk("cmd_accept_timeout", 32'd0, 32'd1);
      acc = -1;
    end else begin
      push_exp(op, a, b);
      acc = cyc + 1;
    end
    @(negedge CLK);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, 32'(ctrl()), 32'd0);
    chk({tag, "_ready"}, 32'(bus.cmd_ready), 32'd0);
    chk({tag, "_outs"},
        32'({bus.op_a, bus.op_b, bus.rsp_valid, bus.rsp_data,
             bus.rsp_op, bus.rsp_err, bus.busy}), 32'd0);
    chk({tag, "_errcnt"}, 32'(bus.err_count), 32'd0);
  endtask

  initial begin
    int acc, acc0, acc1, acc2, n;
    bit seen;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b1;

    repeat (2) @(negedge CLK);
    #1;
    chk_reset_outputs("reset");
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("ready_after_rst", 32'(bus.cmd_ready), 32'd1);
    @(negedge CLK);

    // ADD 200+100 with cycle-exact timing.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd2;
    bus.cmd_a     = 8'd200;
    bus.cmd_b     = 8'd100;
    chk("add_ready", 32'(bus.cmd_ready), 32'd1);
    push_exp(2, 200, 100);
    @(negedge CLK);
    bus.cmd_valid = 1'b0;
    chk("add_ctrl_t1", 32'(ctrl()), 32'b0100);
    @(negedge CLK);
    chk("add_ctrl_t2", 32'(ctrl()), 32'd0);
    chk("add_valid_t2", 32'(bus.rsp_valid), 32'd0);
    @(negedge CLK);
    chk("add_valid_t3", 32'(bus.rsp_valid), 32'd1);
    chk("add_data_t3", 32'(bus.rsp_data), 32'h12C);
    @(negedge CLK);

    // Back-to-back SUB, PASS_A, PASS_B.
    send(3, 3, 5, acc0);
    send(0, 8'hAA, 8'h13, acc1);
    send(1, 8'h77, 8'h55, acc2);
    chk("b2b_gap1", 32'(acc1 - acc0), 32'd4);
    chk("b2b_gap2", 32'(acc2 - acc1), 32'd4);
    drain();

    // Response backpressure with a second command held pending.
    bus.rsp_ready = 1'b0;
    send(2, 7, 9, acc);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd3;
    bus.cmd_a     = 8'd50;
    bus.cmd_b     = 8'd20;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("bp_hold",
          32'({bus.rsp_valid, bus.cmd_ready, ctrl(), bus.rsp_data}),
          32'({1'b1, 1'b0, 4'b0000, 9'd16}));
    end
    bus.rsp_ready = 1'b1;
    send(3, 50, 20, acc);
    chk("bp_accept_next", 32'(acc - hs_cyc), 32'd1);
    drain();

    // Randomised traffic with random response backpressure.
    bp_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), acc);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
    drain();
    bp_mode = 1'b0;
    @(negedge CLK);
    bus.rsp_ready = 1'b1;

    // Faulty unit on ADD: err_count saturates.
    fault = 1'b1;
    for (int i = 0; i < 300; i++)
      send(2, int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), acc);
    drain();
    chk("err_sat", 32'(bus.err_count), 32'd255);
    fault = 1'b0;

    // Reset during WAIT drops the command.
    send(2, 100, 27, acc);
    @(negedge CLK);
    RST = 1'b0;
    void'(q.pop_back());
    model_errs = 0;
    #1;
    chk_reset_outputs("rst_wait");
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("ready_after_rst2", 32'(bus.cmd_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("no_rsp_after_rst", 32'(seen), 32'd0);
    send(2, 1, 1, acc);
    drain();
    chk("post_rst_errcnt", 32'(bus.err_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mux_op_driver.md
# mux_op_driver

Initiator-side sequencer for the registered A/B select-add-subtract result unit. It accepts operand/opcode commands on a valid/ready port and drives the unit's A, B and one-hot control lines for exactly one cycle. It then waits a fixed result latency, captures the unit's `result`, checks it against an internally computed expected value, and returns the result with an error flag on a valid/ready response port. It sits between the test/command fabric and the result unit and is the only driver of that unit's inputs.

## Interface
- `WIDTH`, 8, operand width; result width is WIDTH+1.
- `LAT`, 1, cycles from the issue cycle until `op_result` holds the answer (≥1).
- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command; high only in IDLE.
- `cmd_op` in 2: 0=PASS_A, 1=PASS_B, 2=ADD, 3=SUB.
- `cmd_a`, `cmd_b` in WIDTH: operands.
- `op_a`, `op_b` out WIDTH: operands to the result unit.
- `op_in_data`, `op_sel`, `op_add`, `op_sub` out 1: one-hot control to the result unit, mapped to op 0/1/2/3.
- `op_result` in WIDTH+1: result from the unit.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_data` out WIDTH+1: captured `op_result`.
- `rsp_op` out 2: opcode of the response.
- `rsp_err` out 1: `rsp_data` differs from the expected value.
- `err_count` out 8: saturating mismatch count.
- `busy` out 1: state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`: latch op, a and b, load `op_a`/`op_b`, assert the one matching control line (registered), go to ISSUE.
- **ISSUE** (exactly 1 cycle)
  - The control line is high during this cycle.
  - Compute and register the expected value.
  - Load the wait counter with LAT, go to WAIT.
- **WAIT**
  - All four control lines are 0.
  - `op_a`/`op_b` hold their values.
  - The counter decrements each cycle.
  - In the LAT-th WAIT cycle: capture `op_result` into `rsp_data`, set `rsp_err` = (captured ≠ expected), go to RESP.
- **RESP**
  - `rsp_valid`=1; `rsp_data`, `rsp_op` and `rsp_err` are stable until the handshake.
  - On `rsp_valid && rsp_ready`: go to IDLE and drop `rsp_valid`.
- Control lines are never more than one-hot and are high only in ISSUE.
- Expected value, computed at WIDTH+1 bits with zero-extended operands:
  - PASS_A = {0,A}
  - PASS_B = {0,B}
  - ADD = A+B, carry lands in the MSB
  - SUB = {0,A}−{0,B} mod 2^(WIDTH+1); for example 3−5 = 0x1FE at WIDTH=8.
- `err_count`:
  - Increments on the cycle `rsp_err` is set to 1 on capture.
  - Saturates at 255 and never wraps.
  - Cleared only by reset.
- No command queuing: one command is in flight at a time.

## Timing
- Reset values (asynchronous, while RST=0):
  - state IDLE, but `cmd_ready`=0 while RST is low and 1 on the first cycle after release.
  - `op_a`=`op_b`=0, all control lines 0.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_op`=0, `rsp_err`=0, `err_count`=0, `busy`=0.
- Command handshake at edge T (end of IDLE cycle):
  - ISSUE is cycle T+1.
  - WAIT is T+2 … T+1+LAT; capture occurs at the end of T+1+LAT.
  - `rsp_valid` rises at T+2+LAT, i.e. T+3 for LAT=1.
- Throughput: one command per LAT+3 cycles with zero response backpressure.
- `rsp_ready` low: the block stays in RESP indefinitely, outputs hold, `cmd_ready`=0.
- `cmd_valid` while not IDLE: ignored; the command is not consumed because `cmd_ready`=0.
- The response handshake edge and a new `cmd_valid` cannot overlap; the next command is accepted no earlier than the cycle after leaving RESP.
- Reset in any state:
  - The in-flight command is dropped.
  - Control lines go low immediately.
  - No response is produced.

## Test plan
- Reset, then hold RST=0 mid-run → all outputs at the reset values above; `cmd_ready`=1 the first cycle after release.
- ADD, a=200, b=100, model unit with LAT=1, `rsp_ready`=1 → `op_add` high exactly one cycle (T+1); `rsp_valid` at T+3; `rsp_data`=0x12C, `rsp_op`=2, `rsp_err`=0.
- SUB a=3 b=5, then PASS_A a=0xAA, then PASS_B b=0x55 back-to-back → responses 0x1FE, 0x0AA, 0x055, each with `rsp_err`=0; a new command is accepted every 4 cycles.
- Response backpressure: `rsp_ready`=0 for 5 cycles with `cmd_valid` held high → `rsp_*` stable, `cmd_ready`=0, no second issue; accepted on the cycle after the handshake.
- Model returns result+1 on each ADD → `rsp_err`=1 and `err_count` increments; after 300 faulty commands `err_count`=255.
- Assert RST low during WAIT → control lines 0, `rsp_valid` never rises for that command; a subsequent ADD 1+1 returns 0x002 with no error.
